// File: rtl/if_pingpong_buffer_pkg.sv
// if_pingpong_buffer_pkg: bank states, default sizes and state helpers shared by the input line buffer
package if_pingpong_buffer_pkg;
    localparam int IF_DATA_W = 512;
    localparam int IF_DEPTH = 512;
    localparam int IF_AW = $clog2(IF_DEPTH);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
    function automatic logic is_writable(input bank_state_t s);
        return s == EMPTY || s == FILLING;
    endfunction
    function automatic logic is_readable(input bank_state_t s);
        return s == FULL || s == DRAINING;
    endfunction
endpackage

// File: rtl/if_line_ram.sv
// if_line_ram: simple dual-port read-first RAM with registered, enabled read port
module if_line_ram #(
    parameter int DATA_W = 512,
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/if_pingpong_buffer.sv
// if_pingpong_buffer: two-bank line buffer between the Avalon read master and the conv engine
module if_pingpong_buffer
    import if_pingpong_buffer_pkg::*;
#(
    parameter int DATA_W = IF_DATA_W,
    parameter int DEPTH = IF_DEPTH,
    parameter int AW = IF_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start_i,
    input  logic              IBValid_i,
    input  logic [DATA_W-1:0] IBLine_i,
    input  logic              IBFirst_i,
    input  logic              IBLast_i,
    output logic              Halt_o,
    output logic              RdValid_o,
    output logic [DATA_W-1:0] RdLine_o,
    output logic              RdLast_o,
    input  logic              RdReady_i,
    output logic              Overflow_o
);
    bank_state_t state [2];
    bank_state_t state_nxt [2];
    logic [AW:0] cnt [2];
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt;
    logic wr_bank, rd_bank, wr_acc, issue, done;
    assign wr_acc = IBValid_i && is_writable(state[wr_bank]) && (IBFirst_i || wr_ptr != (AW+1)'(DEPTH));
    assign wr_ptr_nxt = IBFirst_i ? (AW+1)'(1) : wr_ptr + 1'b1;
    assign issue = is_readable(state[rd_bank]) && rd_ptr < cnt[rd_bank] && (!RdValid_o || RdReady_i);
    assign done = RdValid_o && RdReady_i && RdLast_o;
    // write and read transitions always target different banks, so both may apply
    always_comb begin
        state_nxt = state;
        if (wr_acc) state_nxt[wr_bank] = IBLast_i ? FULL : FILLING;
        if (issue) state_nxt[rd_bank] = DRAINING;
        if (done) state_nxt[rd_bank] = EMPTY;
    end
    always_ff @(posedge clk) begin
        if (rst || Start_i) begin
            state <= '{EMPTY, EMPTY};
            cnt <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            Halt_o <= 1'b0;
            RdValid_o <= 1'b0;
            RdLast_o <= 1'b0;
            Overflow_o <= 1'b0;
        end else begin
            state <= state_nxt;
            Halt_o <= !is_writable(state[0]) && !is_writable(state[1]);
            Overflow_o <= Overflow_o || (IBValid_i && !wr_acc);
            if (wr_acc) begin
                wr_ptr <= IBLast_i ? '0 : wr_ptr_nxt;
                if (IBLast_i) begin
                    cnt[wr_bank] <= wr_ptr_nxt;
                    wr_bank <= !wr_bank;
                end
            end
            if (done) begin
                rd_bank <= !rd_bank;
                rd_ptr <= '0;
            end else if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (issue) begin
                RdValid_o <= 1'b1;
                RdLast_o <= rd_ptr == cnt[rd_bank] - 1'b1;
            end else if (RdReady_i) begin
                RdValid_o <= 1'b0;
                RdLast_o <= 1'b0;
            end
        end
    end
    if_line_ram #(.DATA_W(DATA_W), .AW(AW + 1)) u_ram (
        .clk  (clk),
        .we   (wr_acc),
        .waddr({wr_bank, IBFirst_i ? AW'(0) : wr_ptr[AW-1:0]}),
        .wdata(IBLine_i),
        .re   (issue),
        .raddr({rd_bank, rd_ptr[AW-1:0]}),
        .rdata(RdLine_o)
    );
endmodule

// File: tb/tb_if_pingpong_buffer.sv
// tb_if_pingpong_buffer: directed tests of the ping-pong line buffer with a shallow 8-line bank
module tb_if_pingpong_buffer;
    import if_pingpong_buffer_pkg::*;
    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int AW = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic Start_i = 1'b0;
    logic IBValid_i = 1'b0;
    logic IBFirst_i = 1'b0;
    logic IBLast_i = 1'b0;
    logic RdReady_i = 1'b0;
    logic [DW-1:0] IBLine_i = '0;
    logic Halt_o, RdValid_o, RdLast_o, Overflow_o;
    logic [DW-1:0] RdLine_o;
    int vectors = 0;
    int errors = 0;
    always #5 clk = ~clk;
    if_pingpong_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .Start_i(Start_i), .IBValid_i(IBValid_i), .IBLine_i(IBLine_i),
        .IBFirst_i(IBFirst_i), .IBLast_i(IBLast_i), .Halt_o(Halt_o), .RdValid_o(RdValid_o),
        .RdLine_o(RdLine_o), .RdLast_o(RdLast_o), .RdReady_i(RdReady_i), .Overflow_o(Overflow_o)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic put(input logic [DW-1:0] d, input logic f, input logic l);
        IBValid_i = 1'b1;
        IBLine_i = d;
        IBFirst_i = f;
        IBLast_i = l;
        tick;
        IBValid_i = 1'b0;
        IBFirst_i = 1'b0;
        IBLast_i = 1'b0;
    endtask
    task automatic restart;
        Start_i = 1'b1;
        tick;
        Start_i = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        vectors++; if (Halt_o !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", Halt_o); end
        vectors++; if (RdValid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", RdValid_o); end
        vectors++; if (RdLast_o !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", RdLast_o); end
        vectors++; if (Overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", Overflow_o); end
    endtask
    task automatic test_tile4;
        RdReady_i = 1'b1;
        for (int i = 0; i < 4; i++) put(DW'(32'h100 + i), i == 0, i == 3);
        vectors++; if (RdValid_o !== 1'b0) begin errors++; $display("FAIL tile4_early got %b want 0", RdValid_o); end
        for (int i = 0; i < 4; i++) begin
            tick;
            vectors++;
            if ({RdValid_o, RdLast_o, RdLine_o} !== {1'b1, i == 3, DW'(32'h100 + i)}) begin
                errors++;
                $display("FAIL tile4_line%0d got v=%b l=%b d=%h want v=1 l=%b d=%h", i, RdValid_o, RdLast_o, RdLine_o, i == 3, 32'h100 + i);
            end
        end
        tick;
        vectors++; if (RdValid_o !== 1'b0) begin errors++; $display("FAIL tile4_end got %b want 0", RdValid_o); end
        vectors++; if (dut.state[0] !== EMPTY) begin errors++; $display("FAIL tile4_bank0 got %0d want EMPTY", dut.state[0]); end
    endtask
    task automatic test_back_to_back;
        restart;
        RdReady_i = 1'b0;
        for (int i = 0; i < 16; i++) put(DW'(i < 8 ? 32'h200 + i : 32'h300 + i - 8), i % 8 == 0, i % 8 == 7);
        vectors++; if (Halt_o !== 1'b0) begin errors++; $display("FAIL b2b_halt_early got %b want 0", Halt_o); end
        tick;
        vectors++; if (Halt_o !== 1'b1) begin errors++; $display("FAIL b2b_halt_rise got %b want 1", Halt_o); end
        vectors++; if (Overflow_o !== 1'b0) begin errors++; $display("FAIL b2b_ovf_pre got %b want 0", Overflow_o); end
        put(DW'(32'hDEAD), 1'b0, 1'b0);
        vectors++; if ({Overflow_o, Halt_o} !== 2'b11) begin errors++; $display("FAIL b2b_ovf got ovf=%b halt=%b want 1 1", Overflow_o, Halt_o); end
        RdReady_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({RdValid_o, RdLast_o, RdLine_o} !== {1'b1, i == 7, DW'(32'h200 + i)}) begin
                errors++;
                $display("FAIL b2b_bank0_%0d got v=%b l=%b d=%h want v=1 l=%b d=%h", i, RdValid_o, RdLast_o, RdLine_o, i == 7, 32'h200 + i);
            end
            tick;
        end
        vectors++; if ({RdValid_o, Halt_o} !== 2'b01) begin errors++; $display("FAIL b2b_switch got v=%b halt=%b want 0 1", RdValid_o, Halt_o); end
        tick;
        vectors++; if (Halt_o !== 1'b0) begin errors++; $display("FAIL b2b_halt_fall got %b want 0", Halt_o); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({RdValid_o, RdLast_o, RdLine_o} !== {1'b1, i == 7, DW'(32'h300 + i)}) begin
                errors++;
                $display("FAIL b2b_bank1_%0d got v=%b l=%b d=%h want v=1 l=%b d=%h", i, RdValid_o, RdLast_o, RdLine_o, i == 7, 32'h300 + i);
            end
            tick;
        end
        vectors++; if (RdValid_o !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", RdValid_o); end
    endtask
    task automatic test_stall;
        logic [5:0] pat;
        int k;
        pat = 6'b111001;
        k = 0;
        restart;
        RdReady_i = 1'b0;
        for (int i = 0; i < 4; i++) put(DW'(32'h400 + i), i == 0, i == 3);
        tick;
        for (int j = 0; j < 6; j++) begin
            vectors++;
            if ({RdValid_o, RdLast_o, RdLine_o} !== {1'b1, k == 3, DW'(32'h400 + k)}) begin
                errors++;
                $display("FAIL stall_step%0d got v=%b l=%b d=%h want v=1 l=%b d=%h", j, RdValid_o, RdLast_o, RdLine_o, k == 3, 32'h400 + k);
            end
            RdReady_i = pat[j];
            tick;
            if (pat[j]) k++;
        end
        vectors++; if (RdValid_o !== 1'b0) begin errors++; $display("FAIL stall_end got %b want 0", RdValid_o); end
    endtask
    task automatic test_restart;
        restart;
        RdReady_i = 1'b1;
        put(DW'(32'h500), 1'b1, 1'b0);
        put(DW'(32'h501), 1'b0, 1'b0);
        put(DW'(32'h510), 1'b1, 1'b0);
        put(DW'(32'h511), 1'b0, 1'b0);
        put(DW'(32'h512), 1'b0, 1'b1);
        vectors++; if (dut.cnt[0] !== 4'd3) begin errors++; $display("FAIL restart_cnt got %0d want 3", dut.cnt[0]); end
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if ({RdValid_o, RdLast_o, RdLine_o} !== {1'b1, i == 2, DW'(32'h510 + i)}) begin
                errors++;
                $display("FAIL restart_line%0d got v=%b l=%b d=%h want v=1 l=%b d=%h", i, RdValid_o, RdLast_o, RdLine_o, i == 2, 32'h510 + i);
            end
        end
        tick;
        vectors++; if (RdValid_o !== 1'b0) begin errors++; $display("FAIL restart_end got %b want 0", RdValid_o); end
    endtask
    task automatic test_single;
        restart;
        RdReady_i = 1'b1;
        put(DW'(32'h600), 1'b1, 1'b1);
        tick;
        vectors++;
        if ({RdValid_o, RdLast_o, RdLine_o} !== {2'b11, DW'(32'h600)}) begin
            errors++;
            $display("FAIL single_line got v=%b l=%b d=%h want v=1 l=1 d=600", RdValid_o, RdLast_o, RdLine_o);
        end
        tick;
        vectors++; if (RdValid_o !== 1'b0) begin errors++; $display("FAIL single_end got %b want 0", RdValid_o); end
    endtask
    task automatic test_depth_limit;
        restart;
        RdReady_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) put(DW'(32'h900 + i), i == 0, 1'b0);
        vectors++; if (Overflow_o !== 1'b0) begin errors++; $display("FAIL depth_ovf_pre got %b want 0", Overflow_o); end
        put(DW'(32'h9AA), 1'b0, 1'b0);
        vectors++; if (Overflow_o !== 1'b1) begin errors++; $display("FAIL depth_ovf got %b want 1", Overflow_o); end
        put(DW'(32'h9F0), 1'b1, 1'b1);
        tick;
        vectors++;
        if ({RdValid_o, RdLast_o, RdLine_o} !== {2'b11, DW'(32'h9F0)}) begin
            errors++;
            $display("FAIL depth_line got v=%b l=%b d=%h want v=1 l=1 d=9f0", RdValid_o, RdLast_o, RdLine_o);
        end
    endtask
    task automatic test_start_mid;
        restart;
        RdReady_i = 1'b0;
        for (int i = 0; i < 5; i++) put(DW'(32'h700 + i), i == 0, i == 4);
        put(DW'(32'h7F0), 1'b1, 1'b1);
        put(DW'(32'hBAD), 1'b0, 1'b0);
        vectors++;
        if ({Overflow_o, Halt_o, RdValid_o, RdLine_o} !== {3'b111, DW'(32'h700)}) begin
            errors++;
            $display("FAIL start_pre got ovf=%b halt=%b v=%b d=%h want 1 1 1 700", Overflow_o, Halt_o, RdValid_o, RdLine_o);
        end
        RdReady_i = 1'b1;
        tick;
        vectors++; if (RdLine_o !== DW'(32'h701)) begin errors++; $display("FAIL start_line1 got %h want 701", RdLine_o); end
        Start_i = 1'b1;
        tick;
        Start_i = 1'b0;
        vectors++;
        if ({RdValid_o, Halt_o, Overflow_o} !== 3'b000) begin
            errors++;
            $display("FAIL start_clear got v=%b halt=%b ovf=%b want 0 0 0", RdValid_o, Halt_o, Overflow_o);
        end
        put(DW'(32'h800), 1'b1, 1'b0);
        put(DW'(32'h801), 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick;
            vectors++;
            if ({RdValid_o, RdLast_o, RdLine_o} !== {1'b1, i == 1, DW'(32'h800 + i)}) begin
                errors++;
                $display("FAIL start_new%0d got v=%b l=%b d=%h want v=1 l=%b d=%h", i, RdValid_o, RdLast_o, RdLine_o, i == 1, 32'h800 + i);
            end
        end
        vectors++; if (dut.state[1] !== EMPTY) begin errors++; $display("FAIL start_bank1 got %0d want EMPTY", dut.state[1]); end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end
    initial begin
        test_reset;
        test_tile4;
        test_back_to_back;
        test_stall;
        test_restart;
        test_single;
        test_depth_limit;
        test_start_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
